route_line_follower: RTL and testbench

- Parametrised successor to the fixed-route 3-sensor bot controller.
- Drives two H-bridge speed channels (fwd/rev per wheel) from an N-sensor line array.
- Node actions come from a programmable route table instead of hard-coded node states.
- Adds proportional steering, node debounce, lost-line recovery with timeout, and a start/busy/done handshake.

---
 rtl/route_line_follower_if.sv | 37 +++
 rtl/route_line_follower.sv | 213 +++++++++++++++++++++
 tb/tb_route_line_follower.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_line_follower_if.sv
// route_line_follower_if: control, table-write, sensor and motor bundle
// between the route controller and its host.
interface route_line_follower_if #(
  parameter int SENSOR_W  = 3,
  parameter int SPEED_W   = 7,
  parameter int NUM_NODES = 16
);
  localparam int IW = $clog2(NUM_NODES);

  logic                start;
  logic                route_we;
  logic [IW-1:0]       route_addr;
  logic [1:0]          route_wdata;
  logic [IW:0]         route_len;
  logic [SENSOR_W-1:0] sensors;
  logic [SPEED_W-1:0]  speed_l_fwd;
  logic [SPEED_W-1:0]  speed_l_rev;
  logic [SPEED_W-1:0]  speed_r_fwd;
  logic [SPEED_W-1:0]  speed_r_rev;
  logic [IW:0]         node_idx;
  logic                node_pulse;
  logic                busy;
  logic                done;
  logic                lost;

  modport master (
    output start, route_we, route_addr, route_wdata, route_len, sensors,
    input  speed_l_fwd, speed_l_rev, speed_r_fwd, speed_r_rev,
    input  node_idx, node_pulse, busy, done, lost
  );

  modport slave (
    input  start, route_we, route_addr, route_wdata, route_len, sensors,
    output speed_l_fwd, speed_l_rev, speed_r_fwd, speed_r_rev,
    output node_idx, node_pulse, busy, done, lost
  );
endinterface

// File: rtl/route_line_follower.sv
// route_line_follower: N-sensor line follower driven by a programmable
// route table, with P steering, node debounce and lost-line timeout.
module route_line_follower #(
  parameter int SENSOR_W      = 3,
  parameter int SPEED_W       = 7,
  parameter int DIV           = 250,
  parameter int NUM_NODES     = 16,
  parameter int BASE_SPEED    = 60,
  parameter int TURN_SPEED    = 80,
  parameter int KP            = 15,
  parameter int NODE_DEBOUNCE = 4,
  parameter int LOST_TIMEOUT  = 2000
) (
  input logic clk,
  input logic rst_n,
  route_line_follower_if.slave bus
);
  localparam int IW = $clog2(NUM_NODES);
  localparam int LW = IW + 1;
  localparam int C  = SENSOR_W / 2;
  localparam int AW = SPEED_W + 4;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NODE_DEBOUNCE + 1);
  localparam int TW = $clog2(LOST_TIMEOUT + 1);

  localparam logic [SPEED_W-1:0]   Z     = '0;
  localparam logic [SPEED_W-1:0]   BASE  = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0]   TURN  = SPEED_W'(TURN_SPEED);
  localparam logic [4*SPEED_W-1:0] STR   = {BASE, Z, BASE, Z};
  localparam logic [4*SPEED_W-1:0] PIV_R = {TURN, Z, Z, TURN};
  localparam logic [4*SPEED_W-1:0] PIV_L = {Z, TURN, TURN, Z};
  localparam logic signed [AW-1:0] BASE_S = AW'(BASE_SPEED);
  localparam logic signed [AW-1:0] KP_S   = AW'(KP);
  localparam logic signed [AW-1:0] MAX_S  = AW'((1 << SPEED_W) - 1);

  typedef enum logic [2:0] {
    IDLE, FOLLOW, STRAIGHT, TURN_R, TURN_L, RECOVER, DONE, LOST
  } state_t;

  state_t                  state;
  logic [DW-1:0]           div_cnt;
  logic                    tick;
  logic [NUM_NODES-1:0][1:0] tbl;
  logic [LW-1:0]           idx;
  logic [LW-1:0]           len;
  logic [BW-1:0]           deb;
  logic [TW-1:0]           tmo;
  logic                    phase2;
  logic                    last_r;
  logic                    pulse;
  logic                    busy;
  logic                    done;
  logic                    lost;
  logic [4*SPEED_W-1:0]    spd;
  logic [4*SPEED_W-1:0]    fol;
  logic signed [AW-1:0]    lc;
  logic signed [AW-1:0]    rc;
  logic signed [AW-1:0]    diff;
  logic [1:0]              act;
  logic                    all_on;
  logic                    none_on;
  logic                    on_c;
  logic                    deb_hit;
  logic                    tmo_hit;

  function automatic logic [SPEED_W-1:0] sat(input logic signed [AW-1:0] v);
    if (v[AW-1]) return '0;
    if (v > MAX_S) return '1;
    return v[SPEED_W-1:0];
  endfunction

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Sensors left of centre pull the bot left, right of centre pull right.
  always_comb begin
    lc = '0;
    rc = '0;
    for (int i = 0; i < SENSOR_W; i++) begin
      if (bus.sensors[i] && i > C) lc = lc + AW'(1);
      if (bus.sensors[i] && i < C) rc = rc + AW'(1);
    end
  end

  assign diff    = rc - lc;
  assign fol     = {sat(BASE_S + KP_S * diff), Z, sat(BASE_S - KP_S * diff), Z};
  assign all_on  = &bus.sensors;
  assign none_on = ~|bus.sensors;
  assign on_c    = bus.sensors[C];
  assign act     = tbl[idx[IW-1:0]];
  assign deb_hit = (deb == BW'(NODE_DEBOUNCE - 1));
  assign tmo_hit = (tmo == TW'(LOST_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tbl    <= '1;
      idx    <= '0;
      len    <= '0;
      deb    <= '0;
      tmo    <= '0;
      phase2 <= 1'b0;
      last_r <= 1'b1;
      pulse  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lost   <= 1'b0;
      spd    <= '0;
    end else begin
      pulse <= 1'b0;
      if (bus.route_we && !busy)
        tbl[bus.route_addr] <= bus.route_wdata;
      if (bus.start && !busy) begin
        state <= FOLLOW;
        idx   <= '0;
        len   <= bus.route_len;
        deb   <= '0;
        tmo   <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
        lost  <= 1'b0;
      end else if (tick) begin
        unique case (state)
          FOLLOW: begin
            spd <= fol;
            if (diff != '0) last_r <= !diff[AW-1];
            if (none_on) begin
              state <= RECOVER;
              tmo   <= '0;
              deb   <= '0;
              spd   <= last_r ? PIV_R : PIV_L;
            end else if (!all_on) begin
              deb <= '0;
            end else if (!deb_hit) begin
              deb <= deb + 1'b1;
            end else begin
              pulse <= 1'b1;
              deb   <= '0;
              if (idx == len) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                spd   <= '0;
              end else begin
                idx    <= idx + 1'b1;
                tmo    <= '0;
                phase2 <= 1'b0;
                unique case (act)
                  2'b00: begin state <= STRAIGHT; spd <= STR;   end
                  2'b01: begin state <= TURN_R;   spd <= PIV_R; end
                  2'b10: begin state <= TURN_L;   spd <= PIV_L; end
                  default: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    spd   <= '0;
                  end
                endcase
              end
            end
          end
          STRAIGHT: begin
            if (!all_on && on_c) begin
              state <= FOLLOW;
              spd   <= fol;
            end
          end
          // Turn: first lose the line, then reacquire it on the centre.
          TURN_R, TURN_L: begin
            if (phase2 && on_c) begin
              state <= FOLLOW;
              spd   <= fol;
            end else if (tmo_hit) begin
              state <= LOST;
              busy  <= 1'b0;
              lost  <= 1'b1;
              spd   <= '0;
            end else begin
              tmo <= tmo + 1'b1;
              if (none_on) phase2 <= 1'b1;
            end
          end
          RECOVER: begin
            if (!none_on) begin
              state <= FOLLOW;
              spd   <= fol;
            end else if (tmo_hit) begin
              state <= LOST;
              busy  <= 1'b0;
              lost  <= 1'b1;
              spd   <= '0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign {bus.speed_l_fwd, bus.speed_l_rev,
          bus.speed_r_fwd, bus.speed_r_rev} = spd;
  assign bus.node_idx   = idx;
  assign bus.node_pulse = pulse;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.lost       = lost;
endmodule

// File: tb/tb_route_line_follower.sv
// tb_route_line_follower: directed vector table, corner sequences and
// randomized run checked against a behavioural route model.
module tb_route_line_follower;
  localparam int SW = 3;
  localparam int PW = 7;
  localparam int DIV = 4;
  localparam int NN = 16;
  localparam int BS = 60;
  localparam int TS = 80;
  localparam int KP = 15;
  localparam int ND = 4;
  localparam int LT = 10;
  localparam int IW = $clog2(NN);
  localparam int LW = IW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  route_line_follower_if #(.SENSOR_W(SW), .SPEED_W(PW), .NUM_NODES(NN)) bus ();

  route_line_follower #(
    .SENSOR_W(SW), .SPEED_W(PW), .DIV(DIV), .NUM_NODES(NN),
    .BASE_SPEED(BS), .TURN_SPEED(TS), .KP(KP),
    .NODE_DEBOUNCE(ND), .LOST_TIMEOUT(LT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // behavioural model of the route
  string m_mode;
  int m_div, m_idx, m_len, m_deb, m_tmo, m_dir;
  bit m_right, m_phase2, m_pulse, m_busy, m_done, m_lost, m_last_tick;
  int m_table[NN];
  int m_spd[4];

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << PW) - 1) return (1 << PW) - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = "idle";
    m_div = 0; m_idx = 0; m_len = 0; m_deb = 0; m_tmo = 0; m_dir = 1;
    m_right = 1; m_phase2 = 0; m_pulse = 0;
    m_busy = 0; m_done = 0; m_lost = 0; m_last_tick = 0;
    foreach (m_table[i]) m_table[i] = 3;
    m_spd = '{default: 0};
  endtask

  task automatic go_done();
    m_mode = "done"; m_busy = 0; m_done = 1;
  endtask

  task automatic go_lost();
    m_mode = "lost"; m_busy = 0; m_lost = 1;
  endtask

  task automatic node_event();
    int a;
    m_pulse = 1;
    if (m_idx == m_len) begin
      go_done();
      return;
    end
    a = m_table[m_idx % NN];
    m_idx++;
    if (a == 0) m_mode = "straight";
    else if (a == 3) go_done();
    else begin
      m_mode = "turn";
      m_dir = (a == 1) ? 1 : -1;
      m_tmo = 0;
      m_phase2 = 0;
    end
  endtask

  task automatic set_speeds(input int diff);
    bit rgt;
    m_spd = '{default: 0};
    rgt = (m_mode == "turn") ? (m_dir > 0) : m_right;
    if (m_mode == "follow") begin
      m_spd[0] = sat(BS + KP * diff);
      m_spd[2] = sat(BS - KP * diff);
    end else if (m_mode == "straight") begin
      m_spd[0] = BS;
      m_spd[2] = BS;
    end else if (m_mode == "turn" || m_mode == "recover") begin
      if (rgt) begin m_spd[0] = TS; m_spd[3] = TS; end
      else     begin m_spd[2] = TS; m_spd[1] = TS; end
    end
  endtask

  task automatic model_edge();
    logic [SW-1:0] s;
    int lc, rc, diff;
    s = bus.sensors;
    m_last_tick = (m_div == DIV - 1);
    m_div = m_last_tick ? 0 : m_div + 1;
    m_pulse = 0;
    if (bus.route_we && !m_busy) m_table[bus.route_addr] = bus.route_wdata;
    if (bus.start && !m_busy) begin
      m_mode = "follow"; m_idx = 0; m_len = bus.route_len;
      m_done = 0; m_lost = 0; m_deb = 0; m_tmo = 0; m_busy = 1;
      return;
    end
    if (!m_last_tick) return;
    lc = 0; rc = 0;
    for (int i = 0; i < SW; i++)
      if (s[i]) begin
        if (i > SW / 2) lc++;
        else if (i < SW / 2) rc++;
      end
    diff = rc - lc;
    if (m_mode == "follow") begin
      if (diff != 0) m_right = (diff > 0);
      if (s == 0) begin
        m_mode = "recover"; m_tmo = 0; m_deb = 0;
      end else if (&s) begin
        m_deb++;
        if (m_deb == ND) begin m_deb = 0; node_event(); end
      end else m_deb = 0;
    end else if (m_mode == "straight") begin
      if (!(&s) && s[SW / 2]) m_mode = "follow";
    end else if (m_mode == "turn") begin
      if (m_phase2 && s[SW / 2]) m_mode = "follow";
      else begin
        m_tmo++;
        if (m_tmo == LT) go_lost();
        else if (s == 0) m_phase2 = 1;
      end
    end else if (m_mode == "recover") begin
      if (s != 0) m_mode = "follow";
      else begin
        m_tmo++;
        if (m_tmo == LT) go_lost();
      end
    end
    set_speeds(diff);
  endtask

  function automatic logic [63:0] act_vec();
    return 64'({bus.speed_l_fwd, bus.speed_l_rev, bus.speed_r_fwd,
                bus.speed_r_rev, bus.node_idx, bus.node_pulse,
                bus.busy, bus.done, bus.lost});
  endfunction

  function automatic logic [63:0] exp_vec(input int lf, lr, rf, rr, idx,
                                          input bit p, b, d, l);
    return 64'({PW'(lf), PW'(lr), PW'(rf), PW'(rr), LW'(idx), p, b, d, l});
  endfunction

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic check_model(input string nm);
    cmp(nm, act_vec(), exp_vec(m_spd[0], m_spd[1], m_spd[2], m_spd[3],
                               m_idx, m_pulse, m_busy, m_done, m_lost));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_tick();
    int g;
    g = 0;
    do begin
      cyc();
      g++;
    end while (!m_last_tick && g < DIV + 1);
  endtask

  task automatic start_route(input int len);
    bus.route_len = LW'(len);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic write_entry(input int addr, input logic [1:0] data);
    bus.route_we = 1'b1;
    bus.route_addr = IW'(addr);
    bus.route_wdata = data;
    cyc();
    bus.route_we = 1'b0;
  endtask

  typedef struct {
    bit st; bit wr; logic [SW-1:0] s; int n;
    int lf; int lr; int rf; int rr; int idx;
    bit p; bit b; bit d; bit l;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit st, wr, input logic [SW-1:0] s, input int n,
                     input int lf, lr, rf, rr, idx, input bit p, b, d, l);
    vec_t v;
    v.st = st; v.wr = wr; v.s = s; v.n = n;
    v.lf = lf; v.lr = lr; v.rf = rf; v.rr = rr; v.idx = idx;
    v.p = p; v.b = b; v.d = d; v.l = l;
    vt.push_back(v);
  endtask

  logic [SW-1:0] pats [10];

  initial begin
    int hold;
    bus.start = 0; bus.route_we = 0; bus.route_addr = '0;
    bus.route_wdata = '0; bus.route_len = '0; bus.sensors = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset", act_vec(), 64'd0);
    rst_n = 1'b1;

    write_entry(0, 2'b01);
    write_entry(1, 2'b00);
    write_entry(2, 2'b10);

    //  st wr  s      n  lf  lr  rf  rr idx p b d l
    add(1, 0, 3'b010, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0);
    add(0, 1, 3'b010, 1, 60,  0, 60,  0, 0, 0, 1, 0, 0);
    add(0, 0, 3'b111, 4, 80,  0,  0, 80, 1, 1, 1, 0, 0);
    add(0, 0, 3'b000, 1, 80,  0,  0, 80, 1, 0, 1, 0, 0);
    add(0, 0, 3'b010, 1, 60,  0, 60,  0, 1, 0, 1, 0, 0);
    add(0, 0, 3'b001, 1, 75,  0, 45,  0, 1, 0, 1, 0, 0);
    add(0, 0, 3'b100, 1, 45,  0, 75,  0, 1, 0, 1, 0, 0);
    add(0, 0, 3'b111, 4, 60,  0, 60,  0, 2, 1, 1, 0, 0);
    add(0, 0, 3'b111, 2, 60,  0, 60,  0, 2, 0, 1, 0, 0);
    add(0, 0, 3'b010, 1, 60,  0, 60,  0, 2, 0, 1, 0, 0);
    add(0, 0, 3'b111, 4,  0, 80, 80,  0, 3, 1, 1, 0, 0);
    add(0, 0, 3'b000, 1,  0, 80, 80,  0, 3, 0, 1, 0, 0);
    add(0, 0, 3'b010, 1, 60,  0, 60,  0, 3, 0, 1, 0, 0);
    add(0, 0, 3'b111, 4,  0,  0,  0,  0, 3, 1, 0, 1, 0);
    add(1, 0, 3'b010, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0);
    add(0, 0, 3'b001, 1, 75,  0, 45,  0, 0, 0, 1, 0, 0);
    add(0, 0, 3'b000, 1, 80,  0,  0, 80, 0, 0, 1, 0, 0);
    add(0, 0, 3'b000, 9, 80,  0,  0, 80, 0, 0, 1, 0, 0);
    add(0, 0, 3'b000, 1,  0,  0,  0,  0, 0, 0, 0, 0, 1);
    add(1, 0, 3'b010, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0);

    foreach (vt[k]) begin
      bus.sensors = vt[k].s;
      if (vt[k].st) start_route(3);
      if (vt[k].wr) write_entry(1, 2'b11);
      repeat (vt[k].n) run_tick();
      cmp($sformatf("vec%0d", k), act_vec(),
          exp_vec(vt[k].lf, vt[k].lr, vt[k].rf, vt[k].rr, vt[k].idx,
                  vt[k].p, vt[k].b, vt[k].d, vt[k].l));
      check_model($sformatf("vec%0d_model", k));
    end

    // reset in the middle of a right turn
    bus.sensors = 3'b111;
    repeat (4) run_tick();
    cmp("pre_reset_turn", act_vec(), exp_vec(80, 0, 0, 80, 1, 1, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async_reset", act_vec(), 64'd0);
    #2;
    rst_n = 1'b1;
    start_route(3);
    repeat (4) run_tick();
    cmp("table_cleared", act_vec(), exp_vec(0, 0, 0, 0, 1, 1, 0, 1, 0));

    // empty route finishes on the first node
    start_route(0);
    cmp("len0_busy", act_vec(), exp_vec(0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (4) run_tick();
    cmp("len0_done", act_vec(), exp_vec(0, 0, 0, 0, 0, 1, 0, 1, 0));

    // start landing on the tick edge defers the FSM one tick
    bus.sensors = 3'b010;
    for (int g = 0; g < DIV && m_div != DIV - 1; g++) cyc();
    start_route(2);
    cmp("start_on_tick", act_vec(), exp_vec(0, 0, 0, 0, 0, 0, 1, 0, 0));
    run_tick();
    cmp("start_on_tick_next", act_vec(), exp_vec(60, 0, 60, 0, 0, 0, 1, 0, 0));

    pats = '{3'b111, 3'b111, 3'b010, 3'b001, 3'b100,
             3'b000, 3'b011, 3'b110, 3'b101, 3'b010};
    hold = 0;
    for (int c = 0; c < 1600; c++) begin
      if (hold == 0) begin
        bus.sensors = pats[$urandom_range(0, 9)];
        hold = 4 * $urandom_range(1, 6);
      end
      hold--;
      bus.route_we = ($urandom_range(0, 3) == 0);
      bus.route_addr = IW'($urandom);
      bus.route_wdata = 2'($urandom);
      bus.route_len = LW'($urandom_range(0, 5));
      bus.start = ($urandom_range(0, 11) == 0);
      cyc();
      bus.route_we = 1'b0;
      bus.start = 1'b0;
      if (m_last_tick) begin
        check_model("rand");
        cmp("rand_excl",
            64'({bus.speed_l_fwd != 0 && bus.speed_l_rev != 0,
                 bus.speed_r_fwd != 0 && bus.speed_r_rev != 0}), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
